// File: rtl/tile_accumulator.sv
// tile_accumulator: sums 6x6 partial result tiles across input channels, then drains the
// finished tile one element per cycle to output memory with a linear feature-map address.
module tile_accumulator #(
  parameter int IN_W   = 12,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 16,
  parameter int IMG_H  = 64,
  parameter int IMG_W  = 64,
  parameter int ADDR_W = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [5:0][5:0][IN_W-1:0]   in_tile_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [7:0]                  in_od_i,
  input  logic [8:0]                  in_x_i,
  input  logic [8:0]                  in_y_i,
  input  logic                        in_size_i,
  input  logic                        in_last_i,
  output logic                        wr_valid_o,
  input  logic                        wr_ready_i,
  output logic [ADDR_W-1:0]           wr_addr_o,
  output logic [OUT_W-1:0]            wr_data_o,
  output logic                        busy_o
);

  typedef enum logic {ACCUM, DRAIN} state_t;

  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - longint'(1);
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));
  localparam longint OUT_MAX = (longint'(1) <<< (OUT_W-1)) - longint'(1);
  localparam longint OUT_MIN = -(longint'(1) <<< (OUT_W-1));

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a,
                                               input logic [IN_W-1:0]  b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
    if (s > ACC_MAX) s = ACC_MAX;
    else if (s < ACC_MIN) s = ACC_MIN;
    return ACC_W'(s);
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] a);
    longint s;
    s = longint'($signed(a));
    if (s > OUT_MAX) s = OUT_MAX;
    else if (s < OUT_MIN) s = OUT_MIN;
    return OUT_W'(s);
  endfunction

  state_t             r_state;
  logic [ACC_W-1:0]   r_buf [6][6];
  logic [7:0]         r_od;
  logic [8:0]         r_x, r_y;
  logic               r_size;
  logic [15:0]        r_cnt;
  logic [2:0]         r_i, r_j;
  logic               r_wr_valid;
  logic [ADDR_W-1:0]  r_addr;
  logic [OUT_W-1:0]   r_data;

  logic [ACC_W-1:0]   w_sum [6][6];
  logic               w_xfer;
  logic [2:0]         w_lim, w_ni, w_nj;
  logic               w_last_el;
  logic [7:0]         w_od;
  logic [8:0]         w_x, w_y;
  logic [9:0]         w_row, w_col;
  logic               w_inb;
  logic [ADDR_W-1:0]  w_addr;
  logic [ACC_W-1:0]   w_elem;
  logic [OUT_W-1:0]   w_data;

  assign in_ready_o = (r_state == ACCUM);
  assign w_xfer     = in_valid_i && in_ready_o;
  assign wr_valid_o = r_wr_valid;
  assign wr_addr_o  = r_addr;
  assign wr_data_o  = r_data;
  assign busy_o     = (r_state == DRAIN) || (r_cnt != '0);

  always_comb begin
    for (int unsigned i = 0; i < 6; i++)
      for (int unsigned j = 0; j < 6; j++)
        w_sum[i][j] = sat_acc(r_buf[i][j], in_tile_i[i][j]);
  end

  // Outputs are registered, so the element to present next is computed one cycle ahead;
  // on the final accepting transfer it comes straight from the new sums and input metadata.
  always_comb begin
    w_lim     = r_size ? 3'd3 : 3'd5;
    w_last_el = (r_i == w_lim) && (r_j == w_lim);
    if (r_state == ACCUM) begin
      w_ni = '0;
      w_nj = '0;
    end else if (r_j == w_lim) begin
      w_ni = r_i + 3'd1;
      w_nj = '0;
    end else begin
      w_ni = r_i;
      w_nj = r_j + 3'd1;
    end
    w_od   = (r_state == ACCUM) ? in_od_i : r_od;
    w_x    = (r_state == ACCUM) ? in_x_i  : r_x;
    w_y    = (r_state == ACCUM) ? in_y_i  : r_y;
    w_row  = 10'(w_x) + 10'(w_ni);
    w_col  = 10'(w_y) + 10'(w_nj);
    w_inb  = (32'(w_row) < 32'(IMG_H)) && (32'(w_col) < 32'(IMG_W));
    w_addr = ADDR_W'(32'(w_od) * 32'(IMG_H) * 32'(IMG_W) + 32'(w_row) * 32'(IMG_W) + 32'(w_col));
    w_elem = (r_state == ACCUM) ? w_sum[w_ni][w_nj] : r_buf[w_ni][w_nj];
    w_data = sat_out(w_elem);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ACCUM;
      for (int unsigned i = 0; i < 6; i++)
        for (int unsigned j = 0; j < 6; j++)
          r_buf[i][j] <= '0;
      r_od       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_size     <= 1'b0;
      r_cnt      <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_wr_valid <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        ACCUM: if (w_xfer) begin
          for (int unsigned i = 0; i < 6; i++)
            for (int unsigned j = 0; j < 6; j++)
              r_buf[i][j] <= w_sum[i][j];
          r_od   <= in_od_i;
          r_x    <= in_x_i;
          r_y    <= in_y_i;
          r_size <= in_size_i;
          r_cnt  <= r_cnt + 16'd1;
          if (in_last_i) begin
            r_state    <= DRAIN;
            r_i        <= '0;
            r_j        <= '0;
            r_wr_valid <= w_inb;
            r_addr     <= w_addr;
            r_data     <= w_data;
          end
        end
        DRAIN: if (!r_wr_valid || wr_ready_i) begin
          if (w_last_el) begin
            r_state <= ACCUM;
            for (int unsigned i = 0; i < 6; i++)
              for (int unsigned j = 0; j < 6; j++)
                r_buf[i][j] <= '0;
            r_cnt      <= '0;
            r_wr_valid <= 1'b0;
          end else begin
            r_i        <= w_ni;
            r_j        <= w_nj;
            r_wr_valid <= w_inb;
            r_addr     <= w_addr;
            r_data     <= w_data;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule
